// File: rtl/fv_bank_streamer.sv
// Feature-vector bank streamer: queues node requests, reads two FVs per bank word and
// emits sos/eos-framed packets that issue back-to-back once launched.
module fv_bank_streamer #(
    parameter int FV_SIZE    = 16,
    parameter int MAX_FV_NUM = 16,
    parameter int NODE_ID_W  = 8,
    parameter int REQ_DEPTH  = 4,
    parameter int BEAT_W     = $clog2(MAX_FV_NUM/2)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [NODE_ID_W-1:0]            req_node_id,
    input  logic [$clog2(MAX_FV_NUM):0]     req_fv_num,
    input  logic                            rs_available,
    output logic                            mem_rd_en,
    output logic [NODE_ID_W+BEAT_W-1:0]     mem_rd_addr,
    input  logic [2*FV_SIZE-1:0]            mem_rd_data,
    output logic                            out_valid,
    output logic                            out_sos,
    output logic                            out_eos,
    output logic [NODE_ID_W-1:0]            out_node_id,
    output logic [FV_SIZE-1:0]              out_fv0,
    output logic [FV_SIZE-1:0]              out_fv1,
    output logic                            busy
);
    localparam int FNW   = $clog2(MAX_FV_NUM) + 1;
    localparam int CNT_W = BEAT_W + 1;
    localparam int PTR_W = $clog2(REQ_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, GAP} state_t;

    // request FIFO (fv_num stored already clamped)
    logic [NODE_ID_W-1:0] fifo_id [REQ_DEPTH];
    logic [FNW-1:0]       fifo_n  [REQ_DEPTH];
    logic [PTR_W:0]       wr_ptr, rd_ptr;
    logic                 full, empty, push;
    logic [FNW-1:0]       req_n_clamped;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign req_ready = !full;
    // zero-length requests complete the handshake but never enter the queue
    assign push = req_valid && !full && (req_fv_num != '0);
    assign req_n_clamped = (req_fv_num > FNW'(MAX_FV_NUM)) ? FNW'(MAX_FV_NUM) : req_fv_num;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr[PTR_W-1:0]] <= req_node_id;
            fifo_n[wr_ptr[PTR_W-1:0]]  <= req_n_clamped;
        end
    end

    // head-of-queue packet geometry: R real reads, B >= 2 beats
    logic [NODE_ID_W-1:0] head_id;
    logic [FNW-1:0]       head_n, head_half;
    logic [CNT_W-1:0]     head_r, head_b;

    assign head_id   = fifo_id[rd_ptr[PTR_W-1:0]];
    assign head_n    = fifo_n[rd_ptr[PTR_W-1:0]];
    assign head_half = (head_n + FNW'(1)) >> 1;
    assign head_r    = CNT_W'(head_half);
    assign head_b    = (head_r < CNT_W'(2)) ? CNT_W'(2) : head_r;

    state_t               state;
    logic [NODE_ID_W-1:0] cur_id;
    logic [CNT_W-1:0]     cur_r, cur_b, beat;
    logic                 cur_odd;
    logic                 launch, rd_in_read;

    // stage 1: beat launched last cycle, aligned with mem_rd_data
    logic s1_valid, s1_sos, s1_eos, s1_real, s1_lo_only;

    assign launch     = !reset && (state == IDLE) && !empty && rs_available;
    assign rd_in_read = !reset && (state == READ) && (beat < cur_r);
    assign mem_rd_en  = launch || rd_in_read;

    always_comb begin
        mem_rd_addr = '0;
        if (launch)
            mem_rd_addr = {head_id, BEAT_W'(0)};
        else if (rd_in_read)
            mem_rd_addr = {cur_id, beat[BEAT_W-1:0]};
    end

    assign busy = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cur_id     <= '0;
            cur_r      <= '0;
            cur_b      <= '0;
            cur_odd    <= 1'b0;
            beat       <= '0;
            s1_valid   <= 1'b0;
            s1_sos     <= 1'b0;
            s1_eos     <= 1'b0;
            s1_real    <= 1'b0;
            s1_lo_only <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            s1_valid   <= 1'b0;
            s1_sos     <= 1'b0;
            s1_eos     <= 1'b0;
            s1_real    <= 1'b0;
            s1_lo_only <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        rd_ptr     <= rd_ptr + 1'b1;
                        cur_id     <= head_id;
                        cur_r      <= head_r;
                        cur_b      <= head_b;
                        cur_odd    <= head_n[0];
                        beat       <= CNT_W'(1);
                        s1_valid   <= 1'b1;
                        s1_sos     <= 1'b1;
                        s1_real    <= 1'b1;
                        s1_lo_only <= (head_r == CNT_W'(1)) && head_n[0];
                        state      <= READ;
                    end
                end
                READ: begin
                    s1_valid   <= 1'b1;
                    s1_eos     <= (beat == cur_b - CNT_W'(1));
                    s1_real    <= (beat < cur_r);
                    s1_lo_only <= cur_odd && (beat == cur_r - CNT_W'(1));
                    beat       <= beat + CNT_W'(1);
                    if (beat == cur_b - CNT_W'(1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (s1_valid && s1_eos)
                        state <= GAP;
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // output register: everything zero outside valid beats
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_sos     <= 1'b0;
            out_eos     <= 1'b0;
            out_node_id <= '0;
            out_fv0     <= '0;
            out_fv1     <= '0;
        end else begin
            out_valid   <= s1_valid;
            out_sos     <= s1_valid && s1_sos;
            out_eos     <= s1_valid && s1_eos;
            out_node_id <= s1_valid ? cur_id : '0;
            out_fv0     <= (s1_valid && s1_real) ? mem_rd_data[FV_SIZE-1:0] : '0;
            out_fv1     <= (s1_valid && s1_real && !s1_lo_only) ?
                           mem_rd_data[2*FV_SIZE-1:FV_SIZE] : '0;
        end
    end
endmodule

// File: tb/tb_fv_bank_streamer.sv
// Self-checking bench for fv_bank_streamer: packet-level model of beats/reads plus a
// negedge scoreboard; scenario tasks add directed and randomized traffic.
module tb_fv_bank_streamer;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [7:0]  req_node_id;
    logic [4:0]  req_fv_num;
    logic        rs_available;
    logic        mem_rd_en;
    logic [10:0] mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        out_valid, out_sos, out_eos;
    logic [7:0]  out_node_id;
    logic [15:0] out_fv0, out_fv1;
    logic        busy;

    fv_bank_streamer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_node_id(req_node_id), .req_fv_num(req_fv_num),
        .rs_available(rs_available),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_sos(out_sos), .out_eos(out_eos),
        .out_node_id(out_node_id), .out_fv0(out_fv0), .out_fv1(out_fv1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FV contents of a node: always nonzero so zero padding is distinguishable
    function automatic logic [15:0] fv_of(input logic [7:0] node, input int i);
        return 16'(int'(node) * 97 + i * 1031 + 32'h1357);
    endfunction

    // bank: one-cycle read latency, garbage when not reading
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= {fv_of(mem_rd_addr[10:3], 2 * int'(mem_rd_addr[2:0]) + 1),
                            fv_of(mem_rd_addr[10:3], 2 * int'(mem_rd_addr[2:0]))};
        else
            mem_rd_data <= $urandom;
    end

    typedef struct {
        logic        sos, eos;
        logic [7:0]  id;
        logic [15:0] fv0, fv1;
        int          k;
    } beat_t;

    beat_t       exp_bt[$];
    logic [10:0] exp_rd[$];
    int          launch_q[$];
    int tests = 0, fails = 0;
    int acc_cnt = 0, pop_cnt = 0, rd_cnt = 0, beat_cnt = 0;
    int t0 = 0, last_eos = -1;
    bit mon_en = 1'b0, rand_done = 1'b0;

    // packet model: fv_num clamps to 16, B = max(2, ceil(n/2)), zero beyond n
    task automatic model_add(input logic [7:0] id, input int n);
        int nc, r, b;
        beat_t e;
        if (n == 0) return;
        nc = (n > 16) ? 16 : n;
        r  = (nc + 1) / 2;
        b  = (r < 2) ? 2 : r;
        for (int k = 0; k < r; k++) exp_rd.push_back({id, 3'(k)});
        for (int k = 0; k < b; k++) begin
            e.sos = (k == 0);
            e.eos = (k == b - 1);
            e.id  = id;
            e.fv0 = (2 * k < nc) ? fv_of(id, 2 * k) : 16'h0;
            e.fv1 = (2 * k + 1 < nc) ? fv_of(id, 2 * k + 1) : 16'h0;
            e.k   = k;
            exp_bt.push_back(e);
        end
    endtask

    task automatic monitor();
        beat_t e;
        logic [10:0] a;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_rd_en) begin
                    rd_cnt++;
                    tests++;
                    if (exp_rd.size() == 0) begin
                        fails++;
                        $display("FAIL rd_unexpected addr=%h cyc=%0d", mem_rd_addr, cyc);
                    end else begin
                        a = exp_rd.pop_front();
                        if (mem_rd_addr !== a) begin
                            fails++;
                            $display("FAIL rd_addr got=%h exp=%h cyc=%0d", mem_rd_addr, a, cyc);
                        end
                    end
                    if (mem_rd_addr[2:0] == 3'd0) begin
                        t0 = cyc;
                        pop_cnt++;
                        launch_q.push_back(cyc);
                    end
                end
                tests++;
                if (out_valid) begin
                    beat_cnt++;
                    if (exp_bt.size() == 0) begin
                        fails++;
                        $display("FAIL beat_unexpected id=%h eos=%b cyc=%0d", out_node_id, out_eos, cyc);
                    end else begin
                        e = exp_bt.pop_front();
                        if (out_sos !== e.sos || out_eos !== e.eos || out_node_id !== e.id ||
                            out_fv0 !== e.fv0 || out_fv1 !== e.fv1 || cyc != t0 + 2 + e.k) begin
                            fails++;
                            $display("FAIL beat k=%0d got sos=%b eos=%b id=%h fv0=%h fv1=%h cyc=%0d exp sos=%b eos=%b id=%h fv0=%h fv1=%h cyc=%0d",
                                     e.k, out_sos, out_eos, out_node_id, out_fv0, out_fv1, cyc,
                                     e.sos, e.eos, e.id, e.fv0, e.fv1, t0 + 2 + e.k);
                        end
                    end
                    if (out_sos && last_eos >= 0) begin
                        tests++;
                        if (cyc - last_eos < 3) begin
                            fails++;
                            $display("FAIL packet_gap got=%0d exp>=3", cyc - last_eos);
                        end
                    end
                    if (out_eos) last_eos = cyc;
                end else if ({out_sos, out_eos, out_node_id, out_fv0, out_fv1} !== '0) begin
                    fails++;
                    $display("FAIL idle_outputs got sos=%b eos=%b id=%h fv0=%h fv1=%h exp all 0",
                             out_sos, out_eos, out_node_id, out_fv0, out_fv1);
                end
            end
        end
    endtask

    // inputs change 1 time unit after posedge; acceptance judged from ready at negedge
    task automatic push(input logic [7:0] id, input int n);
        logic r = 1'b0;
        int   w = 0;
        req_valid   = 1'b1;
        req_node_id = id;
        req_fv_num  = 5'(n);
        while (!r && w < 300) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            w++;
        end
        if (r) begin
            model_add(id, n);
            if (n > 0) acc_cnt++;
        end else begin
            tests++;
            fails++;
            $display("FAIL push_timeout id=%h got ready=0 exp 1", id);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (exp_bt.size() == 0 && exp_rd.size() == 0 && !busy) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL drain_timeout got beats_left=%0d reads_left=%0d busy=%b exp 0/0/0",
                     exp_bt.size(), exp_rd.size(), busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out_valid, out_sos, out_eos, out_node_id, out_fv0, out_fv1, mem_rd_en, busy} !== '0 ||
            req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state got valid=%b rd_en=%b busy=%b ready=%b exp 0/0/0/1",
                     out_valid, mem_rd_en, busy, req_ready);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        push(8'h12, 6);
        wait_idle();
        push(8'h21, 5);
        wait_idle();
        push(8'h30, 1);
        wait_idle();
        push(8'h31, 2);
        wait_idle();
        push(8'h40, 0);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_len_busy got=%b exp=0", busy);
        end
        wait_idle();
        push(8'h50, 20);
        push(8'h51, 31);
        push(8'h52, 16);
        wait_idle();
    endtask

    task automatic test_fifo_full();
        rs_available = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (req_ready !== ((acc_cnt - pop_cnt) < 4)) begin
                fails++;
                $display("FAIL fifo_ready_%0d got=%b exp=%b", i, req_ready, (acc_cnt - pop_cnt) < 4);
            end
            push(8'h60 + 8'(i), 3 + 2 * i);
        end
        req_valid   = 1'b1;
        req_node_id = 8'h64;
        req_fv_num  = 5'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (req_ready !== 1'b0 || (acc_cnt - pop_cnt) != 4) begin
                fails++;
                $display("FAIL fifo_full_hold got ready=%b exp 0", req_ready);
            end
            @(posedge clk);
            #1;
        end
        rs_available = 1'b1;
        push(8'h64, 4);
        wait_idle();
    endtask

    task automatic test_rs_hold();
        int rd0, bt0, rise;
        rs_available = 1'b0;
        push(8'h33, 4);
        push(8'h34, 7);
        rd0 = rd_cnt;
        bt0 = beat_cnt;
        launch_q.delete();
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (rd_cnt != rd0 || beat_cnt != bt0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rs_hold got reads=%0d beats=%0d busy=%b exp reads=%0d beats=%0d busy=1",
                     rd_cnt, beat_cnt, busy, rd0, bt0);
        end
        rs_available = 1'b1;
        rise = cyc;
        wait_idle();
        tests++;
        if (launch_q.size() != 2 || launch_q[0] != rise) begin
            fails++;
            $display("FAIL rs_launch got n=%0d first=%0d exp n=2 first=%0d",
                     launch_q.size(), (launch_q.size() > 0) ? launch_q[0] : -1, rise);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        push(8'h44, 8);
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (out_valid && !out_sos && !out_eos) hit = 1'b1;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL reset_mid_no_beat1 got=0 exp=1");
        end
        reset  = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({out_valid, out_sos, out_eos, out_node_id, out_fv0, out_fv1, mem_rd_en, busy} !== '0 ||
            req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_state got valid=%b eos=%b rd_en=%b busy=%b ready=%b exp 0/0/0/0/1",
                     out_valid, out_eos, mem_rd_en, busy, req_ready);
        end
        exp_bt.delete();
        exp_rd.delete();
        acc_cnt  = 0;
        pop_cnt  = 0;
        last_eos = -1;
        reset    = 1'b0;
        mon_en   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push(8'h45, 6);
        wait_idle();
    endtask

    task automatic test_random();
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    push(8'($urandom), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 rs_available = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rs_available = 1'b1;
        wait_idle();
    endtask

    initial begin
        req_valid    = 1'b0;
        req_node_id  = '0;
        req_fv_num   = '0;
        rs_available = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_fifo_full();
        test_rs_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
